skew_feeder: RTL and testbench

SKEW_FEEDER -- requirements
Module: skew_feeder

---
 rtl/feeder_pkg.sv | 15 +
 rtl/vec_fifo.sv | 74 +++++++
 rtl/skew_feeder.sv | 142 ++++++++++++++
 tb/tb_skew_feeder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared definitions for the skew feeder: FSM encoding and default geometry.
package feeder_pkg;

  localparam int unsigned DEF_MAX_WIDTH  = 9;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/vec_fifo.sv
// Synchronous vector FIFO with registered occupancy and registered empty/full flags.
module vec_fifo #(
  parameter int unsigned Width = 72,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic [Width-1:0] o_head_c,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic [CntW-1:0]  w_count_nxt;
  logic             r_empty;
  logic             r_full;
  logic             w_push;
  logic             w_pop;

  // Full refuses a push even when a pop happens in the same cycle.
  assign w_push   = i_push & ~r_full;
  assign w_pop    = i_pop & ~r_empty;
  assign o_head_c = r_mem[r_rptr];
  assign o_empty  = r_empty;
  assign o_full   = r_full;

  // Next occupancy from this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CntW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CntW'(1);
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + PtrW'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CntW'(Depth));
    end
  end

  // Storage write; contents need no reset since the flags gate every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/skew_feeder.sv
// Buffers routed vectors and feeds them diagonally skewed (lane i delayed i cycles) into an array.
module skew_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned MaxWidth  = DEF_MAX_WIDTH,
  parameter int unsigned DataWidth = DEF_DATA_WIDTH,
  parameter int unsigned FifoDepth = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vecValid,
  input  logic [MaxWidth*DataWidth-1:0] vecIn,
  input  logic                          lastIn,
  input  logic                          stall,
  output logic                          vecReady,
  output logic [MaxWidth-1:0]           laneValid,
  output logic [MaxWidth*DataWidth-1:0] laneData,
  output logic                          overflow,
  output logic                          done
);

  localparam int unsigned VecW   = MaxWidth * DataWidth;
  localparam int unsigned DrainW = $clog2(MaxWidth + 1);

  feeder_state_e         r_state;
  feeder_state_e         w_state_nxt;
  logic                  w_done_nxt;
  logic                  w_full;
  logic                  w_empty;
  logic [VecW-1:0]       w_head;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_to_drain;
  logic                  r_last_seen;
  logic [DrainW-1:0]     r_drain_cnt;
  logic                  r_overflow;
  logic                  r_done;

  assign vecReady   = ~w_full;
  assign w_accept   = vecValid & ~w_full;
  assign w_issue    = (r_state == STREAM) & ~w_empty & ~stall;
  assign w_to_drain = (r_state == STREAM) & (w_state_nxt == DRAIN);
  assign overflow   = r_overflow;
  assign done       = r_done;

  vec_fifo #(
    .Width (VecW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_accept),
    .i_wdata  (vecIn),
    .i_pop    (w_issue),
    .o_head_c (w_head),
    .o_empty  (w_empty),
    .o_full   (w_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; IDLE also restarts on vectors parked during DRAIN/DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE:    if (w_accept || !w_empty) w_state_nxt = STREAM;
      STREAM:  if (r_last_seen && w_empty) w_state_nxt = DRAIN;
      DRAIN:   if (!stall && (r_drain_cnt == DrainW'(MaxWidth - 1))) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_done_nxt = (w_state_nxt == DONE);
  end

  // End-of-stream latch; a last flag riding on a new vector survives the drain hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_seen <= 1'b0;
    end else if (w_accept && lastIn) begin
      r_last_seen <= 1'b1;
    end else if (w_to_drain) begin
      r_last_seen <= 1'b0;
    end else if ((r_state == STREAM) && !vecValid && lastIn) begin
      r_last_seen <= 1'b1;
    end
  end

  // Counts unstalled DRAIN cycles so the last diagonal leaves the array.
  always_ff @(posedge clk) begin
    if (rst || (r_state != DRAIN)) begin
      r_drain_cnt <= '0;
    end else if (!stall) begin
      r_drain_cnt <= r_drain_cnt + DrainW'(1);
    end
  end

  // Sticky overflow and one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_overflow <= r_overflow | (vecValid & w_full);
      r_done     <= w_done_nxt;
    end
  end

  // Per-lane shift register: stage 0 takes the issued byte, lane l exits at stage l.
  for (genvar l = 0; l < MaxWidth; l++) begin : g_lane
    logic [DataWidth-1:0] r_dat [0:l];
    logic [l:0]           r_vld;

    // Advance the lane's skew chain unless the array holds.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= '0;
        for (int s = 0; s <= l; s++) begin
          r_dat[s] <= '0;
        end
      end else if (!stall) begin
        r_vld[0] <= w_issue;
        r_dat[0] <= w_issue ? w_head[l*DataWidth +: DataWidth] : '0;
        for (int s = 1; s <= l; s++) begin
          r_vld[s] <= r_vld[s-1];
          r_dat[s] <= r_dat[s-1];
        end
      end
    end

    assign laneValid[l]                        = r_vld[l];
    assign laneData[l*DataWidth +: DataWidth]  = r_dat[l];
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench for skew_feeder: per-lane expected byte queues filled at issue, drained by a monitor.
module tb_skew_feeder;

  localparam int unsigned MW = 9;
  localparam int unsigned DW = 8;
  localparam int unsigned FD = 4;
  localparam int unsigned VW = MW * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vecValid = 1'b0;
  logic          lastIn = 1'b0;
  logic          stall = 1'b0;
  logic [VW-1:0] vecIn = '0;
  logic          vecReady;
  logic          overflow;
  logic          done;
  logic [MW-1:0] laneValid;
  logic [VW-1:0] laneData;

  skew_feeder #(
    .MaxWidth  (MW),
    .DataWidth (DW),
    .FifoDepth (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vecValid  (vecValid),
    .vecIn     (vecIn),
    .lastIn    (lastIn),
    .stall     (stall),
    .vecReady  (vecReady),
    .laneValid (laneValid),
    .laneData  (laneData),
    .overflow  (overflow),
    .done      (done)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  logic          edge_stall = 1'b0;
  logic [DW-1:0] lane_q [MW][$];
  logic [DW-1:0] last_exp [MW];
  int            arr_cyc [MW][$];
  int            done_cyc [$];
  logic [DW-1:0] m_b;
  logic [DW-1:0] m_e;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    for (int i = 0; i < MW; i++) begin
      lane_q[i].delete();
      arr_cyc[i].delete();
      last_exp[i] = '0;
    end
    done_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; vecValid = 1'b0; lastIn = 1'b0; stall = 1'b0;
    tick();
    tick();
    clear_sb();
    rst = 1'b0;
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    return VW'({8'($urandom), $urandom, $urandom});
  endfunction

  // Presents one vector for a cycle; expected lane bytes are queued when acceptance is expected.
  task automatic send(input logic [VW-1:0] v, input logic last, input bit acc);
    vecValid = 1'b1; vecIn = v; lastIn = last;
    if (acc) begin
      for (int i = 0; i < MW; i++) lane_q[i].push_back(v[i*DW +: DW]);
    end
    tick();
    vecValid = 1'b0; lastIn = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_cyc.size() == 0 && c < budget) begin
      tick();
      c++;
    end
    if (done_cyc.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done pulse within %0d cycles", budget);
    end
    tick();
    tick();
  endtask

  task automatic chk_arr(input int l, input int k, input int exp);
    if (arr_cyc[l].size() > k) begin
      chk($sformatf("lane%0d_item%0d_cycle", l, k), VW'(arr_cyc[l][k]), VW'(exp));
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL lane%0d_item%0d_cycle: got missing expected %0d", l, k, exp);
    end
  endtask

  task automatic chk_done_at(input string nm, input int exp);
    chk({nm, "_count"}, VW'(done_cyc.size()), VW'(1));
    if (done_cyc.size() > 0) chk(nm, VW'(done_cyc[0]), VW'(exp));
  endtask

  // Lanes valid at time rel after the first of n back-to-back vectors, with no stall.
  function automatic logic [MW-1:0] diag_mask(input int rel, input int n);
    logic [MW-1:0] m = '0;
    for (int i = 0; i < MW; i++) m[i] = (rel - 2 - i >= 0) && (rel - 2 - i < n);
    return m;
  endfunction

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    edge_stall <= stall;
  end

  // Monitor: each fresh valid byte pops its lane queue; held cycles must repeat the last byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cyc.push_back(cyc);
        chk("lanes_idle_at_done", VW'(laneValid), '0);
      end
      for (int i = 0; i < MW; i++) begin
        m_b = laneData[i*DW +: DW];
        if (!laneValid[i]) begin
          chk($sformatf("lane%0d_bubble_zero", i), VW'(m_b), '0);
        end else if (edge_stall) begin
          chk($sformatf("lane%0d_held", i), VW'(m_b), VW'(last_exp[i]));
        end else begin
          arr_cyc[i].push_back(cyc);
          if (lane_q[i].size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL lane%0d_unexpected: got %0h expected none", i, m_b);
          end else begin
            m_e = lane_q[i].pop_front();
            last_exp[i] = m_e;
            chk($sformatf("lane%0d_data", i), VW'(m_b), VW'(m_e));
          end
        end
      end
    end
  end

  initial begin
    int t;
    int sent;
    int x;

    // Reset values while rst is held.
    tick();
    chk("rst_vecReady", VW'(vecReady), VW'(1));
    chk("rst_laneValid", VW'(laneValid), '0);
    chk("rst_laneData", laneData, '0);
    chk("rst_overflow", VW'(overflow), '0);
    chk("rst_done", VW'(done), '0);
    do_reset();

    // Single vector with last: lane i at T+2+i, done at T+2+MW+1.
    t = cyc;
    send(72'h090807060504030201, 1'b1, 1'b1);
    wait_done(60);
    for (int i = 0; i < MW; i++) chk_arr(i, 0, t + 2 + i);
    chk_done_at("single_done", t + 2 + MW + 1);
    do_reset();

    // Five back-to-back vectors: no gaps on any lane.
    t = cyc;
    for (int k = 0; k < 5; k++) send(rnd_vec(), 1'(k == 4), 1'b1);
    wait_done(60);
    for (int i = 0; i < MW; i++)
      for (int k = 0; k < 5; k++) chk_arr(i, k, t + 2 + i + k);
    chk_done_at("b2b_done", t + 4 + 2 + MW + 1);
    do_reset();

    // Three-cycle stall mid-stream freezes outputs and shifts everything by 3.
    t = cyc;
    for (int c = 0; c < 8; c++) begin
      stall = (c >= 3 && c <= 5);
      if (c >= 3 && c <= 6) chk($sformatf("stall_mask_c%0d", c), VW'(laneValid), VW'(diag_mask(3, 5)));
      if (c == 7) chk("stall_mask_resume", VW'(laneValid), VW'(diag_mask(4, 5)));
      if (c < 5) send(rnd_vec(), 1'(c == 4), 1'b1);
      else tick();
    end
    stall = 1'b0;
    wait_done(60);
    for (int i = 0; i < MW; i++)
      for (int k = 0; k < 5; k++) begin
        x = t + 2 + i + k;
        chk_arr(i, k, (x > t + 3) ? x + 3 : x);
      end
    chk_done_at("stall_done", t + 4 + 2 + MW + 1 + 3);
    do_reset();

    // Stalled feeder: four vectors fill the FIFO, the fifth is dropped, overflow sticks.
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fill_ready_%0d", k), VW'(vecReady), VW'(k < 4));
      chk($sformatf("fill_ovf_%0d", k), VW'(overflow), '0);
      send(rnd_vec(), 1'(k == 3), 1'(k < 4));
    end
    chk("drop_overflow", VW'(overflow), VW'(1));
    tick();
    tick();
    stall = 1'b0;
    wait_done(80);
    chk("overflow_sticky", VW'(overflow), VW'(1));
    do_reset();
    chk("overflow_cleared", VW'(overflow), '0);

    // Full FIFO with a pop in the same cycle still refuses the push.
    stall = 1'b1;
    for (int k = 0; k < 4; k++) send(rnd_vec(), 1'(k == 3), 1'b1);
    chk("full_ready", VW'(vecReady), '0);
    stall = 1'b0;
    send(rnd_vec(), 1'b0, 1'b0);
    chk("popfull_overflow", VW'(overflow), VW'(1));
    chk("popfull_ready_cnt3", VW'(vecReady), VW'(1));
    stall = 1'b1;
    send(rnd_vec(), 1'b0, 1'b1);
    chk("refill_ready_cnt4", VW'(vecReady), '0);
    stall = 1'b0;
    wait_done(80);
    do_reset();

    // Reset during DRAIN discards everything and suppresses done.
    t = cyc;
    send(rnd_vec(), 1'b1, 1'b1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    clear_sb();
    chk("rstdrain_laneValid", VW'(laneValid), '0);
    chk("rstdrain_ready", VW'(vecReady), VW'(1));
    chk("rstdrain_done", VW'(done), '0);
    rst = 1'b0;
    repeat (20) tick();
    chk("rstdrain_no_done", VW'(done_cyc.size()), '0);

    // Random streams with random stalls, honouring vecReady.
    for (int s = 0; s < 2; s++) begin
      clear_sb();
      sent = 0;
      for (int c = 0; c < 400 && sent < 30; c++) begin
        stall = ($urandom_range(3) == 0);
        if (vecReady && ($urandom_range(1) == 1)) begin
          send(rnd_vec(), 1'(sent == 29), 1'b1);
          sent++;
        end else begin
          tick();
        end
      end
      stall = 1'b0;
      chk($sformatf("rand%0d_sent", s), VW'(sent), VW'(30));
      wait_done(200);
      chk($sformatf("rand%0d_done_count", s), VW'(done_cyc.size()), VW'(1));
      chk($sformatf("rand%0d_overflow", s), VW'(overflow), '0);
      for (int i = 0; i < MW; i++)
        chk($sformatf("rand%0d_lane%0d_drained", s, i), VW'(lane_q[i].size()), '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
